// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and MEM data access onto one single-ported memory.
// One transaction in flight; data has priority with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_rvalid,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_rvalid,
    output logic                dm_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int unsigned BE_W       = DATA_W / 8;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [1:0]        r_owner;  // bit0 = fetch, bit1 = data, 00 = none
    logic [3:0]        r_starve_cnt;
    logic [3:0]        w_starve_d;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [BE_W-1:0]   r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic w_done;
    logic w_arb;
    logic w_elig_if;
    logic w_elig_dm;
    logic w_grant_if;
    logic w_grant_dm;

    // On completion the owner is excluded: its request line is still up but already served.
    assign w_done     = (r_state == StWait) & mem_rvalid;
    assign w_arb      = (r_state == StIdle) | w_done;
    assign w_elig_if  = w_arb & if_req & ~(w_done & r_owner[0]);
    assign w_elig_dm  = w_arb & dm_req & ~(w_done & r_owner[1]);
    assign w_grant_dm = w_elig_dm & ~(w_elig_if & (r_starve_cnt == STARVE_LIM));
    assign w_grant_if = w_elig_if & ~w_grant_dm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_grant_if || w_grant_dm) w_state_d = StReq;
            StReq:   if (mem_ready) w_state_d = StWait;
            StWait: begin
                if (mem_rvalid) w_state_d = (w_grant_if || w_grant_dm) ? StReq : StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_starve_d = r_starve_cnt;
        if (w_grant_if || !if_req) begin
            w_starve_d = '0;
        end else if (w_grant_dm && (r_starve_cnt != STARVE_LIM)) begin
            w_starve_d = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= 2'b00;
            r_starve_cnt <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_starve_cnt <= w_starve_d;
            if (w_grant_dm) begin
                r_owner     <= 2'b10;
                r_mem_req   <= 1'b1;
                r_mem_we    <= dm_we;
                r_mem_be    <= dm_be;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
            end else if (w_grant_if) begin
                r_owner     <= 2'b01;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end else if (w_done) begin
                r_owner <= 2'b00;
            end else if ((r_state == StReq) && mem_ready) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    always_comb begin
        if_rvalid = w_done & r_owner[0];
        dm_rvalid = w_done & r_owner[1];
        if_rdata  = mem_rdata;
        dm_rdata  = mem_rdata;
        if_stall  = if_req & ~if_rvalid;
        dm_stall  = dm_req & ~dm_rvalid;
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios with literal expectations, then random traffic against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_rvalid (dm_rvalid),
        .dm_stall  (dm_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: at most one pending transaction, described by its fields.
    logic        m_valid;
    logic        m_acc;
    logic        m_is_dm;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_starve;

    // Bench-side requester and memory agents.
    logic f_busy, f_drop, d_busy, d_drop, mp_pend;
    int   mp_cnt;

    task automatic model_step();
        logic exp_mem_req, done, exp_ifv, exp_dmv, free, if_ok, dm_ok, pick_dm, pick_if;
        exp_mem_req = m_valid & ~m_acc;
        done        = m_valid & m_acc & mem_rvalid;
        exp_ifv     = done & ~m_is_dm;
        exp_dmv     = done & m_is_dm;
        chk("rnd_mem_req", 32'(mem_req), 32'(exp_mem_req));
        chk("rnd_if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
        chk("rnd_dm_rvalid", 32'(dm_rvalid), 32'(exp_dmv));
        chk("rnd_if_stall", 32'(if_stall), 32'(if_req & ~exp_ifv));
        chk("rnd_dm_stall", 32'(dm_stall), 32'(dm_req & ~exp_dmv));
        if (exp_mem_req) begin
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_we", 32'(mem_we), 32'(m_we));
            chk("rnd_mem_be", 32'(mem_be), 32'(m_be));
            chk("rnd_mem_wdata", mem_wdata, m_wdata);
        end
        if (exp_ifv) chk("rnd_if_rdata", if_rdata, mem_rdata);
        if (exp_dmv) chk("rnd_dm_rdata", dm_rdata, mem_rdata);

        free    = ~m_valid | done;
        if_ok   = free & if_req & ~exp_ifv;
        dm_ok   = free & dm_req & ~exp_dmv;
        pick_dm = dm_ok & ~(if_ok & (m_starve == STARVE_MAX));
        pick_if = if_ok & ~pick_dm;
        if (pick_if || !if_req) m_starve = 0;
        else if (pick_dm && m_starve < STARVE_MAX) m_starve++;

        if (exp_mem_req && mem_ready) begin
            m_acc   = 1'b1;
            mp_pend = 1'b1;
            mp_cnt  = $urandom_range(3, 1);
        end
        if (free) begin
            m_valid = pick_dm | pick_if;
            m_acc   = 1'b0;
            m_is_dm = pick_dm;
            m_we    = pick_dm ? dm_we : 1'b0;
            m_be    = pick_dm ? dm_be : 4'hF;
            m_addr  = pick_dm ? dm_addr : if_addr;
            m_wdata = pick_dm ? dm_wdata : 32'h0;
        end
        if (exp_ifv) begin f_busy = 1'b0; f_drop = 1'b0; end
        if (exp_dmv) begin d_busy = 1'b0; d_drop = 1'b0; end
    endtask

    task automatic drive_random();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (mp_pend) begin
            mp_cnt--;
            if (mp_cnt == 0) begin
                mem_rvalid = 1'b1;
                mp_pend    = 1'b0;
            end
        end else if ($urandom_range(7) == 0) begin
            mem_rvalid = 1'b1;  // stray, no transaction waiting on it
        end
        mem_ready = ($urandom_range(2) != 0);
        if (!f_busy && $urandom_range(3) == 0) begin
            f_busy  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end else if (f_busy && !f_drop && m_valid && !m_is_dm && $urandom_range(31) == 0) begin
            f_drop = 1'b1;
        end
        if_req = f_busy & ~f_drop;
        if (!d_busy && $urandom_range(2) == 0) begin
            d_busy   = 1'b1;
            dm_we    = $urandom_range(1);
            dm_be    = 4'($urandom);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
        end else if (d_busy && !d_drop && m_valid && m_is_dm && $urandom_range(31) == 0) begin
            d_drop = 1'b1;
        end
        dm_req = d_busy & ~d_drop;
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_be = '0; dm_addr = '0; dm_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 if_req = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rvalid", 32'(if_rvalid), 0);
        chk("rst_dm_rvalid", 32'(dm_rvalid), 0);
        chk("rst_if_stall", 32'(if_stall), 1);
        tick(); if_req = 1'b0; reset = 1'b1;

        // Fetch only
        tick(); if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1;
        @(negedge clk);
        chk("fo_T_stall", 32'(if_stall), 1);
        chk("fo_T_mem_req", 32'(mem_req), 0);
        tick(); @(negedge clk);
        chk("fo_T1_mem_req", 32'(mem_req), 1);
        chk("fo_T1_mem_addr", mem_addr, 32'h10);
        chk("fo_T1_mem_we", 32'(mem_we), 0);
        chk("fo_T1_mem_be", 32'(mem_be), 32'hF);
        chk("fo_T1_stall", 32'(if_stall), 1);
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("fo_T2_if_rvalid", 32'(if_rvalid), 1);
        chk("fo_T2_if_rdata", if_rdata, 32'h0050_0093);
        chk("fo_T2_stall", 32'(if_stall), 0);
        chk("fo_T2_dm_rvalid", 32'(dm_rvalid), 0);
        tick(); if_req = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("fo_T3_mem_req", 32'(mem_req), 0);
        chk("fo_T3_if_rvalid", 32'(if_rvalid), 0);

        // Simultaneous fetch and load
        tick(); if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_we = 1'b0;
        dm_addr = 32'h100; dm_be = 4'hF;
        tick(); @(negedge clk);
        chk("sim_mem_req", 32'(mem_req), 1);
        chk("sim_mem_addr_dm", mem_addr, 32'h100);
        chk("sim_if_stall", 32'(if_stall), 1);
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("sim_dm_rvalid", 32'(dm_rvalid), 1);
        chk("sim_dm_rdata", dm_rdata, 32'h1111_2222);
        chk("sim_if_rvalid0", 32'(if_rvalid), 0);
        tick(); dm_req = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("sim_mem_req_if", 32'(mem_req), 1);
        chk("sim_mem_addr_if", mem_addr, 32'h40);
        chk("sim_mem_we_if", 32'(mem_we), 0);
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h3333_4444;
        @(negedge clk);
        chk("sim_if_rvalid", 32'(if_rvalid), 1);
        chk("sim_if_rdata", if_rdata, 32'h3333_4444);
        chk("sim_dm_rvalid0", 32'(dm_rvalid), 0);
        tick(); if_req = 1'b0; mem_rvalid = 1'b0;

        // Store with memory back-pressure
        tick(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h204;
        dm_wdata = 32'hDEAD_BEEF; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); @(negedge clk);
            chk("st_mem_req", 32'(mem_req), 1);
            chk("st_mem_we", 32'(mem_we), 1);
            chk("st_mem_be", 32'(mem_be), 32'h3);
            chk("st_mem_addr", mem_addr, 32'h204);
            chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("st_dm_rvalid0", 32'(dm_rvalid), 0);
        end
        tick(); mem_ready = 1'b1;
        @(negedge clk);
        chk("st_mem_req_acc", 32'(mem_req), 1);
        tick(); mem_rvalid = 1'b1;
        @(negedge clk);
        chk("st_dm_rvalid", 32'(dm_rvalid), 1);
        chk("st_dm_stall", 32'(dm_stall), 0);
        tick(); dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("st_dm_rvalid_once", 32'(dm_rvalid), 0);
        chk("st_mem_req_idle", 32'(mem_req), 0);

        // Stray response in IDLE
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("stray_if_rvalid", 32'(if_rvalid), 0);
        chk("stray_dm_rvalid", 32'(dm_rvalid), 0);
        chk("stray_mem_req", 32'(mem_req), 0);
        tick(); mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_still_idle", 32'(mem_req), 0);

        // Reset while waiting for a fetch response
        tick(); if_req = 1'b1; if_addr = 32'h80; mem_ready = 1'b1;
        tick(); @(negedge clk);
        chk("rw_mem_req", 32'(mem_req), 1);
        tick(); #1 reset = 1'b0; if_req = 1'b0;
        #1;
        chk("rw_mem_req_rst", 32'(mem_req), 0);
        chk("rw_mem_addr_rst", mem_addr, 0);
        chk("rw_if_rvalid_rst", 32'(if_rvalid), 0);
        tick(); reset = 1'b1;
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("rw_late_if_rvalid", 32'(if_rvalid), 0);
        chk("rw_late_mem_req", 32'(mem_req), 0);
        tick(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h84;
        tick(); @(negedge clk);
        chk("rw_next_mem_req", 32'(mem_req), 1);
        chk("rw_next_mem_addr", mem_addr, 32'h84);
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h00A0_0113;
        @(negedge clk);
        chk("rw_next_if_rvalid", 32'(if_rvalid), 1);
        chk("rw_next_if_rdata", if_rdata, 32'h00A0_0113);
        tick(); if_req = 1'b0; mem_rvalid = 1'b0;

        // Random traffic against the model, from a fresh reset
        reset = 1'b0;
        tick(); reset = 1'b1;
        m_valid = 1'b0; m_acc = 1'b0; m_is_dm = 1'b0; m_we = 1'b0; m_be = '0;
        m_addr = '0; m_wdata = '0; m_starve = 0;
        f_busy = 1'b0; f_drop = 1'b0; d_busy = 1'b0; d_drop = 1'b0; mp_pend = 1'b0; mp_cnt = 0;
        dm_req = 1'b0; if_req = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            drive_random();
            @(negedge clk);
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage RV32I core.
- Arbitrates the two requesters and sequences each transaction over a req/ready + rvalid memory handshake.
- Returns read data or write acknowledges to the winning requester.
- Drives per-requester stall outputs, which the core uses to freeze the affected pipeline stages.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting; the next grant is then forced to fetch. Valid range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_rvalid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid with if_rvalid.
- if_rvalid  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  IF stall = if_req & ~if_rvalid.
- dm_req  in  1  data request; held with its signals stable until dm_rvalid.
- dm_we  in  1  1 = store, 0 = load.
- dm_be  in  DATA_W/8  store byte enables.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid with dm_rvalid.
- dm_rvalid  out  1  one-cycle data completion pulse; also acknowledges stores.
- dm_stall  out  1  MEM stall = dm_req & ~dm_rvalid.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  registered.
- mem_be  out  DATA_W/8  registered.
- mem_addr  out  ADDR_W  registered.
- mem_wdata  out  DATA_W  registered.
- mem_ready  in  1  memory accepts the request in this cycle when mem_req=1.
- mem_rvalid  in  1  response/ack; arrives at earliest 1 cycle after acceptance.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset values (asynchronous on reset=0): state IDLE; owner none; starve_cnt 0; all mem_* outputs 0. if_rvalid and dm_rvalid read 0; stalls follow their equations.
- Exactly one transaction is outstanding at any time.
- FSM states:
  - IDLE: if any eligible request, arbitrate, latch that requester's signals into mem_* and the owner, then go to REQ. For fetch the latched values are mem_we=0, mem_be=all-ones, mem_wdata=0.
  - REQ: mem_req=1 and the mem_* outputs hold. When mem_ready=1: mem_req<=0, go to WAIT.
  - WAIT: when mem_rvalid=1, the owner's rvalid=1 combinationally and its rdata=mem_rdata. In the same cycle, arbitrate among the non-owner requesters only. If one wins, latch it and go to REQ; otherwise go to IDLE. Excluding the owner prevents re-issuing its stale, still-asserted request.
- Arbitration:
  - Data has priority unless starve_cnt==STARVE_MAX and if_req=1, in which case fetch wins.
  - starve_cnt increments on each data grant made while if_req=1.
  - starve_cnt clears on any fetch grant or any cycle with if_req=0.
  - starve_cnt saturates at STARVE_MAX.
- if_rvalid and dm_rvalid are never both 1. Both are 0 outside WAIT.
- mem_rvalid arriving in IDLE or REQ is ignored; it is never forwarded.
- If the requester drops its req after the grant, the transaction still completes and the rvalid pulse is still produced.
- Reset asserted mid-transaction: the FSM returns to IDLE and the in-flight response is dropped per the rule above.
- Minimum latency with mem_ready=1 and rvalid 1 cycle after acceptance:
  - Request seen in IDLE at cycle T, mem_req high at T+1, rvalid at T+2.
  - Back-to-back transactions issue mem_req every 2 cycles.
- Write data is not masked; mem_be carries dm_be unchanged.

Test Plan:
- Fetch-only:
  - Stimulus: if_req=1, if_addr=0x00000010; mem_ready=1; mem_rvalid one cycle after acceptance with 0x00500093.
  - Required: mem_req at T+1 with mem_addr=0x10, mem_we=0; if_rvalid at T+2 with if_rdata=0x00500093; if_stall=1 at T and T+1, 0 at T+2.
- Simultaneous requests:
  - Stimulus: if_req and dm_req (load, addr 0x100) both asserted at T.
  - Required: data granted first (mem_addr=0x100); fetch granted in the dm_rvalid cycle; mem_req for the fetch at the next cycle.
- Store:
  - Stimulus: dm_we=1, dm_be=0b0011, dm_addr=0x204, dm_wdata=0xDEADBEEF; mem_ready held 0 for 3 cycles.
  - Required: mem_req stays 1 with all mem_* signals stable for 3 cycles; dm_rvalid pulses once on the ack.
- Starvation, STARVE_MAX=4:
  - Stimulus: dm_req re-asserted continuously with if_req held high.
  - Required: grants are 4 data grants, then 1 fetch grant; starve_cnt back to 0 after the fetch grant.
- Stray response:
  - Stimulus: mem_rvalid=1 pulsed while in IDLE.
  - Required: if_rvalid and dm_rvalid stay 0; state stays IDLE.
- Reset in WAIT:
  - Stimulus: reset=0 asserted while waiting for a fetch response; response arrives after release.
  - Required: mem_req=0 immediately on assertion; the late response is ignored; the next if_req is serviced normally.
